param_delay: RTL and testbench
==============================

Name: param_delay

Overview:
- Parameterized fixed-latency register pipeline (shift-register delay line).
- Delays a WIDTH-bit bus by exactly DEPTH clock cycles.
- Used in control/datapath blocks to align control strobes with datapath latency, e.g. delaying a start-calculation enable by 3 cycles while feeder data arrives.
- No handshake; data advances every cycle.

Parameters:
- DEPTH, default 1: number of register stages (cycles of latency); legal range 0..1024.
- WIDTH, default 1: bit width of data_in/data_out; legal range >= 1.
- RESET_VALUE, default 0 (WIDTH bits, zero-extended/truncated): value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  data sampled every rising clk edge.
- data_out  output  WIDTH  data_in delayed by DEPTH cycles.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Internal structure: stage[0..DEPTH-1], each WIDTH bits, all registered on rising clk.
- Normal operation (reset=0), every edge: stage[0] <= data_in; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
- data_out = stage[DEPTH-1], driven directly from the register with no output logic.
- Latency: a value present on data_in at edge N appears on data_out after edge N+DEPTH-1, so it is stable during cycle N+DEPTH. Equivalently, data_out(t) = data_in(t-DEPTH).
- Throughput: one new word per cycle, with no bubbles or back-pressure.
- Reset (reset=1 at an edge): every stage <= RESET_VALUE. data_out reads RESET_VALUE from the cycle after that edge.
- Reset mid-operation discards all in-flight words; nothing is preserved.
- Reset has priority over data: data_in sampled at a reset edge is discarded.
- After reset deasserts, data_out holds RESET_VALUE for DEPTH cycles, then presents the first post-reset data_in.
- Before the first reset, stage contents are undefined (X in simulation). No initial values are relied upon.
- DEPTH=0: data_out = data_in purely combinationally. No registers; reset has no effect.
- DEPTH=1: a single register.
- Elaboration checks: WIDTH<1, DEPTH<0 or DEPTH>1024 cause a fatal elaboration error with a message naming the bad parameter.
- No X-propagation masking: X on data_in propagates unchanged.
- Width rules: pure copy; no arithmetic, sign or width conversion.

Optional Feature:
- Macro PARAM_DELAY_TAPS_EN.
- When defined, adds output port taps, width DEPTH*WIDTH. taps[(i+1)*WIDTH-1 : i*WIDTH] = stage[i] for i = 0..DEPTH-1, giving each intermediate pipeline stage for debug or early-look logic.
- Taps are reset to RESET_VALUE along with the stages.
- For DEPTH=0 the taps port is 1 bit, tied to 0.
- When not defined, the port does not exist and stage registers are purely internal; data_in/data_out behaviour is identical in both builds.

Test Plan:
- DEPTH=3, WIDTH=1, RESET_VALUE=0: hold reset 2 cycles, then a single 1-cycle pulse data_in=1 at edge 10 -> data_out=1 only in the cycle after edge 12, 0 before and after.
- DEPTH=3, WIDTH=1: data_in held at 1 from edge 5 (control-unit start level) -> data_out rises after edge 7 and stays 1.
- DEPTH=4, WIDTH=8: incrementing stream 0x01, 0x02, ... each cycle -> data_out shows the same sequence shifted by exactly 4 cycles, with no gaps or duplicates.
- DEPTH=4, WIDTH=8, RESET_VALUE=0xA5: stream running, assert reset 1 cycle at edge 20 -> data_out=0xA5 from edge 20 through edge 24; post-reset data appears after edge 24.
- DEPTH=0, WIDTH=16: drive 0x1234 then 0xBEEF -> data_out equals data_in in the same cycle; asserting reset has no effect.
- PARAM_DELAY_TAPS_EN, DEPTH=3, WIDTH=4: inject 0x7 -> 0x7 appears in taps[3:0], then taps[7:4], then taps[11:8] on three successive edges, matching data_out at the last.

Source files
------------

// File: rtl/param_delay.sv
// param_delay: fixed-latency shift-register delay line.
// Delays a WIDTH-bit bus by exactly DEPTH clock cycles (data_out(t) = data_in(t-DEPTH)).
// Synchronous active-high reset loads RESET_VALUE into every stage.
// DEPTH=0 degenerates to a combinational wire, and reset then has no effect.
// Optional build macro PARAM_DELAY_TAPS_EN adds a 'taps' output that exposes every stage.
module param_delay #(
   parameter int               DEPTH       = 1,
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   localparam int              TAPS_W      = (DEPTH <= 0) ? 1 : DEPTH * WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
`ifdef PARAM_DELAY_TAPS_EN
   ,
   output logic [TAPS_W-1:0] taps
`endif
);

   // Reject illegal configurations at elaboration time.
   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "param_delay: illegal WIDTH=%0d (must be >= 1)", WIDTH);
   end
   if (DEPTH < 0) begin : g_bad_depth_lo
      $fatal(1, "param_delay: illegal DEPTH=%0d (must be >= 0)", DEPTH);
   end
   if (DEPTH > 1024) begin : g_bad_depth_hi
      $fatal(1, "param_delay: illegal DEPTH=%0d (must be <= 1024)", DEPTH);
   end

   if (DEPTH == 0) begin : g_wire
      // No stages: clock and reset are intentionally ignored.
      logic unused_ok;
      assign unused_ok = ^{clk, reset};

      // Zero latency: output follows input combinationally.
      always_comb begin
         data_out = data_in;
      end

`ifdef PARAM_DELAY_TAPS_EN
      // No stages to expose; tap port is a single constant bit.
      always_comb begin
         taps = '0;
      end
`endif
   end else begin : g_pipe
      localparam int unsigned N = unsigned'(DEPTH);

      logic [WIDTH-1:0] stage_q [N];
      logic [WIDTH-1:0] stage_d [N];

      // Next-state: reset loads RESET_VALUE everywhere, otherwise shift by one stage.
      always_comb begin
         stage_d = stage_q;
         for (int unsigned i = 0; i < N; i++) begin
            if (reset) begin
               stage_d[i] = RESET_VALUE;
            end else if (i == 0) begin
               stage_d[i] = data_in;
            end else begin
               stage_d[i] = stage_q[i-1];
            end
         end
      end

      // Stage registers advance on every rising edge.
      always_ff @(posedge clk) begin
         stage_q <= stage_d;
      end

      // Output comes straight from the last register.
      always_comb begin
         data_out = stage_q[N-1];
      end

`ifdef PARAM_DELAY_TAPS_EN
      // Flatten all stages onto the debug tap bus, stage 0 in the low slice.
      always_comb begin
         taps = '0;
         for (int unsigned i = 0; i < N; i++) begin
            taps[i*WIDTH +: WIDTH] = stage_q[i];
         end
      end
`endif
   end

endmodule

// File: tb/tb_param_delay.sv
// tb_param_delay: directed scoreboard bench for param_delay.
// Stimulus pushes hand-computed expected outputs into a queue; a monitor pops and compares.
module tb_param_delay;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: DEPTH=3, WIDTH=1, RESET_VALUE=0
   logic       rst_a = 1'b0;
   logic       din_a = 1'b0;
   logic       out_a;
   // DUT B: DEPTH=4, WIDTH=8, RESET_VALUE=0xA5
   logic       rst_b = 1'b0;
   logic [7:0] din_b = '0;
   logic [7:0] out_b;
   // DUT C: DEPTH=0, WIDTH=16
   logic        rst_c = 1'b0;
   logic [15:0] din_c = '0;
   logic [15:0] out_c;

`ifdef PARAM_DELAY_TAPS_EN
   logic [2:0]  taps_a;
   logic [31:0] taps_b;
   logic [0:0]  taps_c;
   // DUT T: DEPTH=3, WIDTH=4, taps exposed
   logic        rst_t = 1'b0;
   logic [3:0]  din_t = '0;
   logic [3:0]  out_t;
   logic [11:0] taps_t;
`endif

   param_delay #(.DEPTH(3), .WIDTH(1), .RESET_VALUE(1'b0)) u_a (
      .clk(clk), .reset(rst_a), .data_in(din_a), .data_out(out_a)
`ifdef PARAM_DELAY_TAPS_EN
      , .taps(taps_a)
`endif
   );

   param_delay #(.DEPTH(4), .WIDTH(8), .RESET_VALUE(8'hA5)) u_b (
      .clk(clk), .reset(rst_b), .data_in(din_b), .data_out(out_b)
`ifdef PARAM_DELAY_TAPS_EN
      , .taps(taps_b)
`endif
   );

   param_delay #(.DEPTH(0), .WIDTH(16)) u_c (
      .clk(clk), .reset(rst_c), .data_in(din_c), .data_out(out_c)
`ifdef PARAM_DELAY_TAPS_EN
      , .taps(taps_c)
`endif
   );

`ifdef PARAM_DELAY_TAPS_EN
   param_delay #(.DEPTH(3), .WIDTH(4), .RESET_VALUE(4'h0)) u_t (
      .clk(clk), .reset(rst_t), .data_in(din_t), .data_out(out_t), .taps(taps_t)
   );
`endif

   typedef struct {
      int          ch;
      logic [15:0] exp;
      logic [15:0] exp2;
      bit          chk;
   } item_t;

   item_t q[$];
   int    n_vec  = 0;
   int    n_fail = 0;

   // Drive one cycle of stimulus for a channel and queue the response expected after the next edge.
   task automatic apply(input int ch, input logic rst, input logic [15:0] din,
                        input logic [15:0] exp, input logic [15:0] exp2);
      item_t it;
      @(negedge clk);
      case (ch)
         0: begin rst_a = rst; din_a = din[0];   end
         1: begin rst_b = rst; din_b = din[7:0]; end
         2: begin rst_c = rst; din_c = din;      end
`ifdef PARAM_DELAY_TAPS_EN
         3: begin rst_t = rst; din_t = din[3:0]; end
`endif
         default: ;
      endcase
      it.ch   = ch;
      it.exp  = exp;
      it.exp2 = exp2;
      it.chk  = 1'b1;
      q.push_back(it);
   endtask

   // Monitor: sample just after each rising edge and compare against the queue head.
   always @(posedge clk) begin
      item_t       m;
      logic [15:0] act;
      #1;
      if (q.size() > 0) begin
         m = q.pop_front();
         if (m.chk) begin
            case (m.ch)
               0: begin
                  act = {15'b0, out_a};
                  n_vec++;
                  if (act !== m.exp) begin
                     n_fail++;
                     $display("FAIL d3w1_out: got %h, want %h", act, m.exp);
                  end
               end
               1: begin
                  act = {8'b0, out_b};
                  n_vec++;
                  if (act !== m.exp) begin
                     n_fail++;
                     $display("FAIL d4w8_out: got %h, want %h", act, m.exp);
                  end
               end
               2: begin
                  act = out_c;
                  n_vec++;
                  if (act !== m.exp) begin
                     n_fail++;
                     $display("FAIL d0w16_out: got %h, want %h", act, m.exp);
                  end
               end
`ifdef PARAM_DELAY_TAPS_EN
               3: begin
                  act = {4'b0, taps_t};
                  n_vec++;
                  if (act !== m.exp) begin
                     n_fail++;
                     $display("FAIL d3w4_taps: got %h, want %h", act, m.exp);
                  end
                  act = {12'b0, out_t};
                  n_vec++;
                  if (act !== m.exp2) begin
                     n_fail++;
                     $display("FAIL d3w4_out: got %h, want %h", act, m.exp2);
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   initial begin
      // Single pulse at edge 10 on a 3-deep line: visible only after edge 12.
      apply(0, 1'b1, 16'h0, 16'h0, 16'h0);
      apply(0, 1'b1, 16'h0, 16'h0, 16'h0);
      for (int k = 3; k <= 15; k++) begin
         apply(0, 1'b0, (k == 10) ? 16'h1 : 16'h0, (k == 12) ? 16'h1 : 16'h0, 16'h0);
      end

      // Level held from edge 5: output rises after edge 7 and stays high.
      apply(0, 1'b1, 16'h0, 16'h0, 16'h0);
      for (int k = 2; k <= 10; k++) begin
         apply(0, 1'b0, (k >= 5) ? 16'h1 : 16'h0, (k >= 7) ? 16'h1 : 16'h0, 16'h0);
      end

      // Incrementing stream on a 4-deep line, reset pulse at edge 20.
      apply(1, 1'b1, 16'h0, 16'h00A5, 16'h0);
      for (int k = 2; k <= 27; k++) begin
         logic [15:0] e;
         if (k == 20 || k < 5 || (k > 20 && k < 24)) e = 16'h00A5;
         else                                        e = 16'(k - 4);
         apply(1, (k == 20), 16'(k - 1), e, 16'h0);
      end

      // Zero-depth line is a wire; reset is ignored.
      apply(2, 1'b0, 16'h1234, 16'h1234, 16'h0);
      apply(2, 1'b0, 16'hBEEF, 16'hBEEF, 16'h0);
      apply(2, 1'b1, 16'hBEEF, 16'hBEEF, 16'h0);
      apply(2, 1'b1, 16'h0000, 16'h0000, 16'h0);
      apply(2, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0);

`ifdef PARAM_DELAY_TAPS_EN
      // 0x7 walks through taps slices on successive edges.
      apply(3, 1'b1, 16'h0, 16'h000, 16'h0);
      apply(3, 1'b0, 16'h7, 16'h007, 16'h0);
      apply(3, 1'b0, 16'h0, 16'h070, 16'h0);
      apply(3, 1'b0, 16'h0, 16'h700, 16'h7);
      apply(3, 1'b0, 16'h0, 16'h000, 16'h0);
`endif

      repeat (4) @(negedge clk);
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
